// File: rtl/cppg_wb.sv
// cppg_wb: lattice-gas propagation write-back engine; calc words -> FIFO -> VRAM (x, Y).
// Optional overrun detection on err is enabled by defining CPPG_WB_OVERRUN_CHK_EN.
`timescale 1ns/1ps
module cppg_wb #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        PPGWR,
  input  logic [13:0] C_VRAMADR_Y,
  input  logic [9:0]  dsizx,
  input  logic        calc_valid,
  input  logic [63:0] calc_data,
  output logic        calc_ready,
  output logic        vram_req,
  input  logic        vram_ack,
  output logic [9:0]  vram_adr_x,
  output logic [13:0] vram_adr_y,
  output logic [63:0] wdata,
  output logic        row_done,
  output logic        busy,
  output logic        err
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [7:0]            in_cnt_q, in_cnt_d;
  logic [7:0]            out_cnt_q, out_cnt_d;
  logic [13:0]           y_q, y_d;
  logic                  armed_q, armed_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [63:0]           mem_q [DEPTH];

  logic fifo_full, fifo_empty, push, pop, start;
  logic unused_dsizx_hi;

  assign unused_dsizx_hi = ^dsizx[9:8];

  assign fifo_full  = (cnt_q == CNT_W'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign calc_ready = (state_q == RUN) && !fifo_full && (in_cnt_q < n_q);
  assign vram_req   = (state_q == RUN) && !fifo_empty;
  assign push       = calc_valid && calc_ready;
  assign pop        = vram_req && vram_ack;
  // A new row needs PPGWR to have been seen low since the previous one.
  assign start      = (state_q == IDLE) && PPGWR && armed_q;

  assign wdata      = vram_req ? mem_q[rd_ptr_q] : 64'd0;
  assign vram_adr_x = {2'b00, out_cnt_q};
  assign vram_adr_y = y_q;
  assign row_done   = (state_q == DONE);
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    y_d       = y_q;
    armed_d   = armed_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (!PPGWR) armed_d = 1'b1;
        if (start) begin
          state_d   = RUN;
          armed_d   = 1'b0;
          n_d       = dsizx[7:0];
          y_d       = C_VRAMADR_Y;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          cnt_d     = '0;
        end
      end
      RUN: begin
        if (!PPGWR) begin
          state_d   = IDLE;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          cnt_d     = '0;
        end else begin
          if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            in_cnt_d = in_cnt_q + 8'd1;
          end
          if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            out_cnt_d = out_cnt_q + 8'd1;
          end
          cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
          if (out_cnt_q == n_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q   <= IDLE;
      n_q       <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      y_q       <= '0;
      armed_q   <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      y_q       <= y_d;
      armed_q   <= armed_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: wdata is masked while no request is pending.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= calc_data;
  end

`ifdef CPPG_WB_OVERRUN_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start) err_d = 1'b0;
    else if ((state_q == RUN) && calc_valid && !calc_ready) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
